// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// PcRedirectCtrl (module pc_redirect_ctrl)
//
// Purpose:
//    Sequences the fetch PC register. It arbitrates branch and trap redirect
//    requests and holds the PC while fetch is stalled. It issues a one-cycle
//    jump_flag_o/jump_addr_o pair to the PC register. It also generates the
//    post-reset boot delay, the IF/ID flush window and the misaligned-target
//    fault pulse.
//
// Parameters:
//    BOOT_CYCLES  - cycles spent in BOOT after reset release
//    FLUSH_CYCLES - cycles flush_o stays high after a jump issues (>= 1)
//    TRAP_VEC     - target substituted when a requested target is misaligned
//    CNT_W        - width of the saturating redirect counter
//
// Ports:
//    clk            - clock
//    rst_           - synchronous, active-high reset
//    stall_i        - fetch/imem not ready; PC must hold
//    br_flag_i      - branch redirect request from EX
//    br_addr_i      - branch target
//    trap_flag_i    - trap redirect request (wins over a branch)
//    trap_addr_i    - trap handler target
//    pc_en_o        - PC register advance enable
//    jump_flag_o    - single-cycle jump pulse to the PC register
//    jump_addr_o    - jump target; holds its last value between jumps
//    flush_o        - kill instructions in IF/ID
//    fetch_valid_o  - fetched word this cycle is valid
//    misalign_o     - pulses with jump_flag_o when the target was misaligned
//    redirect_cnt_o - saturating count of issued jumps
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
   parameter int unsigned BOOT_CYCLES  = 4,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             stall_i,
   input  logic             br_flag_i,
   input  logic [31:0]      br_addr_i,
   input  logic             trap_flag_i,
   input  logic [31:0]      trap_addr_i,
   output logic             pc_en_o,
   output logic             jump_flag_o,
   output logic [31:0]      jump_addr_o,
   output logic             flush_o,
   output logic             fetch_valid_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   // Counter widths are sized from the parameters, with a floor of one bit so
   // that BOOT_CYCLES of 0 or 1 still produce a legal vector.
   localparam int unsigned BOOT_W  = (BOOT_CYCLES  < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam int unsigned FLUSH_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   localparam logic [BOOT_W-1:0]  BOOT_INIT  = BOOT_W'(BOOT_CYCLES);
   localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES);
   localparam logic [BOOT_W-1:0]  BOOT_ONE   = BOOT_W'(1);
   localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_e;

   state_e             state_q,       state_d;
   logic [BOOT_W-1:0]  bootCnt_q,     bootCnt_d;
   logic [FLUSH_W-1:0] flushCnt_q,    flushCnt_d;
   logic               pendTrap_q,    pendTrap_d;
   logic [31:0]        pendAddr_q,    pendAddr_d;
   logic               pendMis_q,     pendMis_d;
   logic               jumpFlag_q,    jumpFlag_d;
   logic [31:0]        jumpAddr_q,    jumpAddr_d;
   logic               misalign_q,    misalign_d;
   logic [CNT_W-1:0]   redirectCnt_q, redirectCnt_d;

   logic        reqValid;
   logic [31:0] reqTarget;
   logic        reqMis;
   logic [31:0] reqAddr;

   logic        mergeTrap;
   logic [31:0] mergeAddr;
   logic        mergeMis;

   logic        issueNow;
   logic [31:0] issueAddr;
   logic        issueMis;

   // Request selection: a trap beats a branch in the same cycle. A target
   // with nonzero low bits is replaced by the trap vector, and the fault
   // flag travels with the request so that it pulses together with the jump.
   always_comb begin
      reqValid  = trap_flag_i | br_flag_i;
      reqTarget = trap_flag_i ? trap_addr_i : br_addr_i;
      reqMis    = (reqTarget[1:0] != 2'b00);
      reqAddr   = reqMis ? TRAP_VEC : reqTarget;
   end

   // Pending-entry merge while in HOLD. A trap replaces a pending branch.
   // A branch never replaces anything, because it sits on the wrong path
   // behind the redirect that is already pending. A second trap leaves the
   // older pending trap in place.
   always_comb begin
      mergeTrap = pendTrap_q;
      mergeAddr = pendAddr_q;
      mergeMis  = pendMis_q;
      if (trap_flag_i && !pendTrap_q) begin
         mergeTrap = 1'b1;
         mergeAddr = reqAddr;
         mergeMis  = reqMis;
      end
   end

   // Next-state logic. The flush countdown runs first, so a redirect
   // accepted during FLUSH overrides it and restarts the window. Every path
   // that issues a jump funnels through issueNow. This keeps the jump pulse,
   // the target, the fault pulse and the counter consistent with each other.
   always_comb begin
      state_d       = state_q;
      bootCnt_d     = bootCnt_q;
      flushCnt_d    = flushCnt_q;
      pendTrap_d    = pendTrap_q;
      pendAddr_d    = pendAddr_q;
      pendMis_d     = pendMis_q;
      jumpFlag_d    = 1'b0;
      jumpAddr_d    = jumpAddr_q;
      misalign_d    = 1'b0;
      redirectCnt_d = redirectCnt_q;
      issueNow      = 1'b0;
      issueAddr     = reqAddr;
      issueMis      = reqMis;

      case (state_q)
         // Boot ends in the cycle the count reaches zero. This gives exactly
         // BOOT_CYCLES cycles of BOOT after release, with a minimum of one.
         // Redirect requests are ignored here.
         BOOT: begin
            if (bootCnt_q <= BOOT_ONE) begin
               state_d   = RUN;
               bootCnt_d = '0;
            end else begin
               bootCnt_d = bootCnt_q - BOOT_ONE;
            end
         end

         RUN, FLUSH: begin
            if (state_q == FLUSH) begin
               if (flushCnt_q <= FLUSH_ONE) begin
                  state_d    = RUN;
                  flushCnt_d = '0;
               end else begin
                  flushCnt_d = flushCnt_q - FLUSH_ONE;
               end
            end
            if (reqValid) begin
               if (stall_i) begin
                  state_d    = HOLD;
                  pendTrap_d = trap_flag_i;
                  pendAddr_d = reqAddr;
                  pendMis_d  = reqMis;
               end else begin
                  issueNow = 1'b1;
               end
            end
         end

         HOLD: begin
            pendTrap_d = mergeTrap;
            pendAddr_d = mergeAddr;
            pendMis_d  = mergeMis;
            if (!stall_i) begin
               issueNow  = 1'b1;
               issueAddr = mergeAddr;
               issueMis  = mergeMis;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase

      if (issueNow) begin
         state_d    = FLUSH;
         flushCnt_d = FLUSH_INIT;
         jumpFlag_d = 1'b1;
         jumpAddr_d = issueAddr;
         misalign_d = issueMis;
         if (redirectCnt_q != CNT_MAX) begin
            redirectCnt_d = redirectCnt_q + CNT_ONE;
         end
      end
   end

   // State register. Reset wins over everything, including a jump computed
   // for the coming cycle, so a redirect accepted under reset never issues.
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q       <= BOOT;
         bootCnt_q     <= BOOT_INIT;
         flushCnt_q    <= '0;
         pendTrap_q    <= 1'b0;
         pendAddr_q    <= '0;
         pendMis_q     <= 1'b0;
         jumpFlag_q    <= 1'b0;
         jumpAddr_q    <= '0;
         misalign_q    <= 1'b0;
         redirectCnt_q <= '0;
      end else begin
         state_q       <= state_d;
         bootCnt_q     <= bootCnt_d;
         flushCnt_q    <= flushCnt_d;
         pendTrap_q    <= pendTrap_d;
         pendAddr_q    <= pendAddr_d;
         pendMis_q     <= pendMis_d;
         jumpFlag_q    <= jumpFlag_d;
         jumpAddr_q    <= jumpAddr_d;
         misalign_q    <= misalign_d;
         redirectCnt_q <= redirectCnt_d;
      end
   end

   // Output decode. The PC advances only in RUN/FLUSH with fetch ready, and
   // never in the cycle the PC register is loading a jump target. The
   // fetched word is additionally invalid while the flush window is open.
   always_comb begin
      pc_en_o        = ((state_q == RUN) || (state_q == FLUSH)) && !stall_i && !jumpFlag_q;
      flush_o        = (state_q == FLUSH);
      fetch_valid_o  = pc_en_o && !flush_o;
      jump_flag_o    = jumpFlag_q;
      jump_addr_o    = jumpAddr_q;
      misalign_o     = misalign_q;
      redirect_cnt_o = redirectCnt_q;
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pc_redirect_ctrl.
//
// A cycle-counting reference model predicts the outputs. It tracks the
// cycles since reset release, the cycle where the flush window closes, a
// pending redirect and a jump scheduled for the next cycle. Directed steps
// come first, and a randomized tail follows.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

   localparam int unsigned BOOT_N  = 4;
   localparam int unsigned FLUSH_N = 2;
   localparam int unsigned CW      = 2;
   localparam logic [31:0] TV      = 32'h0000_0100;
   localparam int unsigned CNT_SAT = (1 << CW) - 1;

   logic          clk;
   logic          rst_;
   logic          stall_i;
   logic          br_flag_i;
   logic [31:0]   br_addr_i;
   logic          trap_flag_i;
   logic [31:0]   trap_addr_i;
   logic          pc_en_o;
   logic          jump_flag_o;
   logic [31:0]   jump_addr_o;
   logic          flush_o;
   logic          fetch_valid_o;
   logic          misalign_o;
   logic [CW-1:0] redirect_cnt_o;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   int          mCyc;
   int          mFlushEnd;
   bit          mPendValid;
   bit          mPendTrap;
   logic [31:0] mPendAddr;
   bit          mPendMis;
   bit          mJumpNow;
   logic [31:0] mLastAddr;
   bit          mMis;
   int          mCnt;

   pc_redirect_ctrl #(
      .BOOT_CYCLES (BOOT_N),
      .FLUSH_CYCLES(FLUSH_N),
      .TRAP_VEC    (TV),
      .CNT_W       (CW)
   ) dut (
      .clk           (clk),
      .rst_          (rst_),
      .stall_i       (stall_i),
      .br_flag_i     (br_flag_i),
      .br_addr_i     (br_addr_i),
      .trap_flag_i   (trap_flag_i),
      .trap_addr_i   (trap_addr_i),
      .pc_en_o       (pc_en_o),
      .jump_flag_o   (jump_flag_o),
      .jump_addr_o   (jump_addr_o),
      .flush_o       (flush_o),
      .fetch_valid_o (fetch_valid_o),
      .misalign_o    (misalign_o),
      .redirect_cnt_o(redirect_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mCyc       = 0;
      mFlushEnd  = 0;
      mPendValid = 0;
      mPendTrap  = 0;
      mPendAddr  = '0;
      mPendMis   = 0;
      mJumpNow   = 0;
      mLastAddr  = '0;
      mMis       = 0;
      mCnt       = 0;
   endtask

   function automatic bit modelBooted();
      int bootLen;
      bootLen = (BOOT_N > 0) ? int'(BOOT_N) : 1;
      return mCyc >= bootLen;
   endfunction

   // Compare every output against the model for the current cycle's inputs.
   task automatic checkOutput();
      bit active;
      bit expFlush;
      bit expPcEn;
      active   = modelBooted() && !mPendValid;
      expFlush = active && (mCyc < mFlushEnd);
      expPcEn  = active && !stall_i && !mJumpNow;
      checkBit ("pc_en",       pc_en_o,       expPcEn);
      checkBit ("fetch_valid", fetch_valid_o, expPcEn && !expFlush);
      checkBit ("flush",       flush_o,       expFlush);
      checkBit ("jump_flag",   jump_flag_o,   mJumpNow);
      checkWord("jump_addr",   jump_addr_o,   mLastAddr);
      checkBit ("misalign",    misalign_o,    mMis);
      checkWord("redirect_cnt", 32'(redirect_cnt_o), 32'(mCnt));
   endtask

   // Advance the model across one clock edge using this cycle's inputs.
   task automatic modelUpdate();
      bit          doJump;
      logic [31:0] tgt;
      logic [31:0] jAddr;
      bit          jMis;
      bit          reqMis;
      logic [31:0] reqAddr;
      if (rst_) begin
         modelReset();
         return;
      end
      doJump  = 0;
      jAddr   = '0;
      jMis    = 0;
      tgt     = trap_flag_i ? trap_addr_i : br_addr_i;
      reqMis  = (tgt % 4) != 0;
      reqAddr = reqMis ? TV : tgt;
      if (modelBooted()) begin
         if (mPendValid) begin
            if (trap_flag_i && !mPendTrap) begin
               mPendTrap = 1;
               mPendAddr = reqAddr;
               mPendMis  = reqMis;
            end
            if (!stall_i) begin
               doJump     = 1;
               jAddr      = mPendAddr;
               jMis       = mPendMis;
               mPendValid = 0;
            end
         end else if (trap_flag_i || br_flag_i) begin
            if (stall_i) begin
               mPendValid = 1;
               mPendTrap  = trap_flag_i;
               mPendAddr  = reqAddr;
               mPendMis   = reqMis;
            end else begin
               doJump = 1;
               jAddr  = reqAddr;
               jMis   = reqMis;
            end
         end
      end
      mJumpNow = doJump;
      mMis     = doJump && jMis;
      if (doJump) begin
         mLastAddr = jAddr;
         mFlushEnd = mCyc + 1 + int'(FLUSH_N);
         if (mCnt < int'(CNT_SAT)) mCnt++;
      end
      mCyc++;
   endtask

   // One clock cycle: drive the inputs, check the outputs mid-cycle, step
   // the model, and return just after the next rising edge.
   task automatic applyStimulus(input logic r, input logic s, input logic b,
                                input logic [31:0] ba, input logic t,
                                input logic [31:0] ta);
      rst_        = r;
      stall_i     = s;
      br_flag_i   = b;
      br_addr_i   = ba;
      trap_flag_i = t;
      trap_addr_i = ta;
      @(negedge clk);
      checkOutput();
      modelUpdate();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rt;
      $display("[TB] pc_redirect_ctrl test start");
      rst_        = 1'b1;
      stall_i     = 1'b0;
      br_flag_i   = 1'b0;
      br_addr_i   = '0;
      trap_flag_i = 1'b0;
      trap_addr_i = '0;
      modelReset();
      @(posedge clk);
      #1;

      // Reset for two cycles, then the boot delay and a little RUN time
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(BOOT_N);
      checkBit("boot_done_pc_en", pc_en_o, 1'b1);
      idle(2);

      // Plain branch
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEC, 1'b0, 32'h0);
      checkBit ("br_jump_flag", jump_flag_o, 1'b1);
      checkWord("br_jump_addr", jump_addr_o, 32'hDEAD_BEEC);
      idle(4);

      // Trap and branch in the same cycle
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0200);
      checkWord("prio_jump_addr", jump_addr_o, 32'h0000_0200);
      idle(4);

      // Misaligned branch target
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
      checkWord("mis_jump_addr", jump_addr_o, TV);
      checkBit ("mis_pulse",     misalign_o,  1'b1);
      idle(4);

      // Stalled branch overwritten by a trap, issued after the stall drops
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0300);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
      checkWord("hold_jump_addr", jump_addr_o, 32'h0000_0300);
      idle(4);

      // Back-to-back redirects restart the flush and saturate the counter
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1000 + 32'(i * 16), 1'b0, 32'h0);
      end
      checkWord("cnt_saturated", 32'(redirect_cnt_o), CNT_SAT);
      idle(4);

      // Reset in the accept cycle cancels the jump
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
      checkBit("rst_cancel_jump", jump_flag_o, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(BOOT_N + 2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         ra = $urandom();
         rt = $urandom();
         if ($urandom_range(0, 9) < 7) ra[1:0] = 2'b00;
         if ($urandom_range(0, 9) < 7) rt[1:0] = 2'b00;
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), ra,
                       ($urandom_range(0, 9) == 0), rt);
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
